// File: rtl/laser_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// laser_pkg : packetizer state encoding and default header byte
// Revision  : 1.0
// ============================================================================
package laser_pkg;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HDR_SEND  = 4'd1,
        HDR_WAIT  = 4'd2,
        COLLECT_A = 4'd3,
        COLLECT_B = 4'd4,
        PAY_SEND  = 4'd5,
        PAY_WAIT  = 4'd6,
        TRL_SEND  = 4'd7,
        TRL_WAIT  = 4'd8
    } laser_state_t;

endpackage
`default_nettype wire

// File: rtl/laser_checksum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// laser_checksum : per-lane XOR accumulators for the packet trailer
// Revision       : 1.0
// ============================================================================
module laser_checksum (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       load1,
    input  logic       load2,
    input  logic [7:0] data,
    output logic [7:0] sum1,
    output logic [7:0] sum2
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum1 <= 8'h00;
            sum2 <= 8'h00;
        end else if (clear) begin
            sum1 <= 8'h00;
            sum2 <= 8'h00;
        end else begin
            if (load1) begin
                sum1 <= sum1 ^ data;
            end
            if (load2) begin
                sum2 <= sum2 ^ data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/laser_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// laser_counter : generic up-counter with synchronous clear, wraps at 2^WIDTH
// Revision      : 1.0
// ============================================================================
module laser_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/laser_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// laser_packetizer : frames host byte pairs into header/payload/trailer beats
//                    for a two-lane laser transmitter
// Revision         : 1.0
// ============================================================================
module laser_packetizer
    import laser_pkg::*;
#(
    parameter int         PAYLOAD_PAIRS = 4,
    parameter logic [7:0] HEADER_BYTE   = HEADER_BYTE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       flush,
    output logic [7:0] tx_data1,
    output logic [7:0] tx_data2,
    output logic       tx_ready1,
    output logic       tx_ready2,
    input  logic       tx_done,
    output logic       tx_en,
    output logic       busy
);

    localparam logic [7:0] LAST_BEAT = 8'(PAYLOAD_PAIRS - 1);

    laser_state_t state;
    logic         pad_flag;
    logic [7:0]   lane1;
    logic         tx_ready;
    logic [7:0]   beat_count;
    logic [7:0]   seq;
    logic [7:0]   sum1;
    logic [7:0]   sum2;

    logic         collecting;
    logic         take;
    logic         pad_load;
    logic         load_lane;
    logic         load1;
    logic         load2;
    logic [7:0]   load_byte;
    logic         last_beat;
    logic         beat_inc;
    logic         packet_done;

    assign collecting  = (state == COLLECT_A) || (state == COLLECT_B);
    assign host_ready  = collecting && !pad_flag;
    assign take        = host_valid && host_ready;
    // A host byte always beats flush; padding starts only on an idle host cycle.
    assign pad_load    = collecting && (pad_flag || (flush && !host_valid));
    assign load_lane   = take || pad_load;
    assign load_byte   = take ? host_data : 8'h00;
    assign load1       = load_lane && (state == COLLECT_A);
    assign load2       = load_lane && (state == COLLECT_B);
    assign last_beat   = (beat_count == LAST_BEAT);
    assign beat_inc    = (state == PAY_WAIT) && tx_done && !last_beat;
    assign packet_done = (state == TRL_WAIT) && tx_done;

    assign tx_ready1 = tx_ready;
    assign tx_ready2 = tx_ready;
    assign busy      = tx_en;

    laser_counter #(.WIDTH(8)) u_beat_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (packet_done),
        .inc     (beat_inc),
        .count   (beat_count)
    );

    laser_counter #(.WIDTH(8)) u_seq_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (packet_done),
        .count   (seq)
    );

    laser_checksum u_checksum (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (packet_done),
        .load1   (load1),
        .load2   (load2),
        .data    (load_byte),
        .sum1    (sum1),
        .sum2    (sum2)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pad_flag <= 1'b0;
            lane1    <= 8'h00;
            tx_data1 <= 8'h00;
            tx_data2 <= 8'h00;
            tx_ready <= 1'b0;
            tx_en    <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            if (collecting && flush && !host_valid) begin
                pad_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (host_valid) begin
                        state    <= HDR_SEND;
                        tx_data1 <= HEADER_BYTE;
                        tx_data2 <= seq;
                        tx_ready <= 1'b1;
                        tx_en    <= 1'b1;
                    end
                end
                HDR_SEND: state <= HDR_WAIT;
                HDR_WAIT: begin
                    if (tx_done) begin
                        state <= COLLECT_A;
                    end
                end
                COLLECT_A: begin
                    if (load_lane) begin
                        lane1 <= load_byte;
                        state <= COLLECT_B;
                    end
                end
                COLLECT_B: begin
                    if (load_lane) begin
                        tx_data1 <= lane1;
                        tx_data2 <= load_byte;
                        tx_ready <= 1'b1;
                        state    <= PAY_SEND;
                    end
                end
                PAY_SEND: state <= PAY_WAIT;
                PAY_WAIT: begin
                    if (tx_done) begin
                        if (last_beat) begin
                            tx_data1 <= sum1;
                            tx_data2 <= sum2;
                            tx_ready <= 1'b1;
                            state    <= TRL_SEND;
                        end else begin
                            state <= COLLECT_A;
                        end
                    end
                end
                TRL_SEND: state <= TRL_WAIT;
                TRL_WAIT: begin
                    if (tx_done) begin
                        state    <= IDLE;
                        pad_flag <= 1'b0;
                        tx_en    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_laser_packetizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_laser_packetizer : directed stimulus against a packet-level model
// Revision            : 1.0
// ============================================================================
module tb_laser_packetizer;

    localparam int         PP  = 4;
    localparam logic [7:0] HDR = 8'hA5;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic [7:0] host_data  = 8'h00;
    logic       host_valid = 1'b0;
    logic       flush      = 1'b0;
    logic       auto_done  = 1'b0;
    logic       stray_done = 1'b0;
    logic       tx_done;
    logic       host_ready;
    logic [7:0] tx_data1;
    logic [7:0] tx_data2;
    logic       tx_ready1;
    logic       tx_ready2;
    logic       tx_en;
    logic       busy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] seen[$];
    logic [15:0] exp_beat;
    logic [7:0]  pb [0:2*PP-1];
    logic [7:0]  model_seq  = 8'h00;
    int          done_delay = 1;
    logic        hold_done  = 1'b0;
    int          base;

    assign tx_done = auto_done | stray_done;

    always #5 clock = ~clock;

    laser_packetizer #(
        .PAYLOAD_PAIRS (PP),
        .HEADER_BYTE   (HDR)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .flush      (flush),
        .tx_data1   (tx_data1),
        .tx_data2   (tx_data2),
        .tx_ready1  (tx_ready1),
        .tx_ready2  (tx_ready2),
        .tx_done    (tx_done),
        .tx_en      (tx_en),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Packet model: header, zero-padded payload pairs, XOR trailer per lane.
    task automatic push_packet(input int nbytes);
        logic [7:0] b1, b2, x1, x2;
        x1 = 8'h00;
        x2 = 8'h00;
        exp_q.push_back({HDR, model_seq});
        for (int i = 0; i < PP; i++) begin
            b1 = (2*i     < nbytes) ? pb[2*i]     : 8'h00;
            b2 = (2*i + 1 < nbytes) ? pb[2*i + 1] : 8'h00;
            exp_q.push_back({b1, b2});
            x1 = x1 ^ b1;
            x2 = x2 ^ b2;
        end
        exp_q.push_back({x1, x2});
        model_seq = model_seq + 8'h01;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        host_data  = b;
        host_valid = 1'b1;
        while (!host_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!host_ready) bound_fail("host_accept");
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (busy) bound_fail("packet_end");
    endtask

    task automatic run_packet(input int nbytes, input logic use_flush);
        push_packet(nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(pb[i]);
        host_valid = 1'b0;
        if (use_flush) flush = 1'b1;
        wait_idle();
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data1"},   tx_data1,   0);
        check({tag, "_tx_data2"},   tx_data2,   0);
        check({tag, "_tx_ready1"},  tx_ready1,  0);
        check({tag, "_tx_ready2"},  tx_ready2,  0);
        check({tag, "_host_ready"}, host_ready, 0);
        check({tag, "_tx_en"},      tx_en,      0);
        check({tag, "_busy"},       busy,       0);
    endtask

    // Compare process: every pulse is matched against the model queue.
    always @(negedge clock) begin
        if (reset_n) begin
            check("ready_lanes_equal", tx_ready1, tx_ready2);
            check("busy_eq_tx_en", busy, tx_en);
            if (tx_ready1) begin
                seen.push_back({tx_data1, tx_data2});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: actual=%0h required=none", {tx_data1, tx_data2});
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {tx_data1, tx_data2}, exp_beat);
                end
            end
        end
    end

    // Transmitter: answers each pulse with tx_done after done_delay cycles.
    initial begin
        logic        pending;
        int          waited;
        logic [15:0] cap;
        pending = 1'b0;
        waited  = 0;
        cap     = 16'h0000;
        forever begin
            @(negedge clock);
            auto_done = 1'b0;
            if (!reset_n) begin
                pending = 1'b0;
            end else if (pending) begin
                waited++;
                check("wait_data_stable", {tx_data1, tx_data2}, cap);
                if (waited >= done_delay && !hold_done) begin
                    auto_done = 1'b1;
                    pending   = 1'b0;
                end else if (waited > 1000) begin
                    bound_fail("tx_done_hold");
                    pending = 1'b0;
                end
            end else if (tx_ready1) begin
                cap     = {tx_data1, tx_data2};
                pending = 1'b1;
                waited  = 0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Sequential bytes 01..08, tx_done three cycles after each pulse.
        done_delay = 3;
        base = seen.size();
        for (int i = 0; i < 2*PP; i++) pb[i] = 8'(i + 1);
        push_packet(2*PP);
        host_data  = 8'h01;
        host_valid = 1'b1;
        @(negedge clock);
        check("first_pulse_latency", tx_ready1, 1);
        for (int i = 0; i < 2*PP; i++) send_byte(pb[i]);
        host_valid = 1'b0;
        wait_idle();
        check("p0_header",  seen[base],     16'hA500);
        check("p0_beat1",   seen[base + 1], 16'h0102);
        check("p0_beat4",   seen[base + 4], 16'h0708);
        check("p0_trailer", seen[base + 5], 16'h0008);

        // Three bytes then flush: zero padding through the last beat.
        done_delay = 1;
        base = seen.size();
        pb[0] = 8'h11; pb[1] = 8'h22; pb[2] = 8'h33;
        run_packet(3, 1'b1);
        check("p1_header",  seen[base],     16'hA501);
        check("p1_beat2",   seen[base + 2], 16'h3300);
        check("p1_beat3",   seen[base + 3], 16'h0000);
        check("p1_trailer", seen[base + 5], 16'h2222);

        // Held tx_done in PAY_WAIT: host stalls and lane data stays put.
        done_delay = 2;
        for (int i = 0; i < 2*PP; i++) pb[i] = 8'(8'h3C + 8'(i * 8'h11));
        pb[1] = 8'hC3;
        push_packet(2*PP);
        send_byte(pb[0]);
        hold_done = 1'b1;
        send_byte(pb[1]);
        host_data  = pb[2];
        host_valid = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("hold_host_ready", host_ready, 0);
            check("hold_tx_data", {tx_data1, tx_data2}, 16'h3CC3);
        end
        hold_done = 1'b0;
        for (int i = 2; i < 2*PP; i++) send_byte(pb[i]);
        host_valid = 1'b0;
        wait_idle();

        // Stray tx_done and flush in IDLE, stray tx_done in COLLECT_A.
        @(negedge clock);
        stray_done = 1'b1;
        flush      = 1'b1;
        @(negedge clock);
        stray_done = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("idle_stray_busy", busy, 0);
            check("idle_stray_pulse", tx_ready1, 0);
        end
        flush = 1'b0;
        for (int i = 0; i < 2*PP; i++) pb[i] = 8'(8'hE0 + i);
        push_packet(2*PP);
        host_data  = pb[0];
        host_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!host_ready && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (!host_ready) bound_fail("reach_collect_a");
        end
        host_valid = 1'b0;
        stray_done = 1'b1;
        @(negedge clock);
        stray_done = 1'b0;
        check("collect_stray_ready", host_ready, 1);
        check("collect_stray_pulse", tx_ready1, 0);
        @(negedge clock);
        check("collect_stray_ready2", host_ready, 1);
        for (int i = 0; i < 2*PP; i++) send_byte(pb[i]);
        host_valid = 1'b0;
        wait_idle();

        // Reset while waiting in PAY_WAIT abandons the packet.
        for (int i = 0; i < 2*PP; i++) pb[i] = 8'(8'h5A + i);
        push_packet(2*PP);
        send_byte(pb[0]);
        hold_done = 1'b1;
        send_byte(pb[1]);
        repeat (2) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        model_seq  = 8'h00;
        hold_done  = 1'b0;
        host_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 257 back-to-back packets: seq 00..FF then wraps to 00.
        done_delay = 1;
        base = seen.size();
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 2*PP; i++) pb[i] = 8'(p * 8 + i);
            run_packet(2*PP, 1'b0);
        end
        check("wrap_first_header", seen[base],           16'hA500);
        check("wrap_ff_header",    seen[base + 6*255],   16'hA5FF);
        check("wrap_last_header",  seen[base + 6*256],   16'hA500);
        check("wrap_pulse_count",  seen.size() - base,   6*257);

        repeat (4) @(negedge clock);
        check("model_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/laser_packetizer.md
LASER_PACKETIZER -- requirements
Module: laser_packetizer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter: PAYLOAD_PAIRS, default 4, number of payload beats per packet (range 1..255).
REQ-003 Parameter: HEADER_BYTE, default 8'hA5, lane-1 byte of the header beat.
REQ-004 Port: clock  input  1  system clock; all state on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: host_data  input  8  byte from host stream.
REQ-007 Port: host_valid  input  1  host_data holds a byte.
REQ-008 Port: host_ready  output  1  block accepts host_data this cycle.
REQ-009 Port: flush  input  1  level; pads and closes a partially filled packet.
REQ-010 Port: tx_data1, tx_data2  output  8 each  lane bytes to the transmitter.
REQ-011 Port: tx_ready1, tx_ready2  output  1 each  one-cycle pulse; lane bytes valid; always equal.
REQ-012 Port: tx_done  input  1  one-cycle pulse from the transmitter; beat finished.
REQ-013 Port: tx_en  output  1  laser enable; high from packet start to trailer done.
REQ-014 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 A host byte SHALL transfer only on cycles where host_valid && host_ready.
REQ-016 Packet format, per beat (lane1/lane2): header (HEADER_BYTE / seq), then PAYLOAD_PAIRS payload beats (first byte / second byte of each host pair), then a trailer (XOR of all lane-1 payload bytes / XOR of all lane-2 payload bytes).
REQ-017 FSM states SHALL be IDLE, HDR_SEND, HDR_WAIT, COLLECT_A, COLLECT_B, PAY_SEND, PAY_WAIT, TRL_SEND, TRL_WAIT.
REQ-018 IDLE -> HDR_SEND when host_valid=1; no byte is consumed in IDLE; flush in IDLE SHALL be ignored.
REQ-019 Each *_SEND state SHALL last exactly one cycle, drive tx_ready1=tx_ready2=1, and go to its *_WAIT state.
REQ-020 *_WAIT SHALL hold tx_data1/tx_data2 stable until tx_done=1; tx_done in any other state SHALL be ignored.
REQ-021 HDR_WAIT -> COLLECT_A on tx_done.
REQ-022 host_ready SHALL be 1 only in COLLECT_A and COLLECT_B with flush padding inactive.
REQ-023 COLLECT_A: an accepted byte loads lane 1 -> COLLECT_B; COLLECT_B: an accepted byte loads lane 2 -> PAY_SEND.
REQ-024 In COLLECT_A/B, flush=1 with host_valid=0 SHALL set a sticky pad flag; padding loads 8'h00 into the current lane, one lane per cycle, with host_ready=0.
REQ-025 If flush and host_valid are both 1 in the same cycle, the host byte SHALL win.
REQ-026 PAY_WAIT on tx_done: if beat count = PAYLOAD_PAIRS-1 -> TRL_SEND, else increment count -> COLLECT_A.
REQ-027 TRL_WAIT on tx_done -> IDLE; seq SHALL increment mod 256 (8'hFF -> 8'h00); beat count, checksums and pad flag SHALL clear.
REQ-028 Checksums SHALL update on every lane load, including pad bytes (pad 8'h00 leaves the checksum unchanged).
REQ-029 tx_en SHALL be 1 in every state except IDLE; busy SHALL equal tx_en.
REQ-030 Latency: from host_valid rising in IDLE to the first tx_ready pulse SHALL be 1 cycle.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, with seq=0, beat count=0, checksums=0, pad flag=0.
REQ-032 Output reset values: tx_data1=tx_data2=8'h00, tx_ready1=tx_ready2=0, host_ready=0, tx_en=0, busy=0.
REQ-033 Reset mid-packet SHALL abandon the packet, with no trailer and no seq increment.

Structure
REQ-034 The state enum and default HEADER_BYTE SHALL live in the shared laser package.
REQ-035 The beat counter and seq counter SHALL reuse the existing Counter module.
REQ-036 One sub-module, laser_checksum, SHALL hold the two XOR accumulators with load/clear inputs.

Verification
REQ-037 Host sends 8'h01..8'h08, tx_done 3 cycles after each pulse -> beats A5/00, 01/02, 03/04, 05/06, 07/08, trailer 8'h01^8'h03^8'h05^8'h07=8'h00 / 8'h02^8'h04^8'h06^8'h08=8'h08.
REQ-038 Host sends 3 bytes 8'h11,8'h22,8'h33 then flush=1 -> beats 11/22, 33/00, 00/00, 00/00, trailer 8'h22/8'h22.
REQ-039 Run 257 back-to-back packets -> header lane-2 seq runs 00..FF then 00.
REQ-040 host_valid=1 in COLLECT_A with tx_done held low in PAY_WAIT -> host_ready=0 and tx_data stable until tx_done.
REQ-041 Assert reset_n=0 during PAY_WAIT -> all outputs at reset values immediately; the next packet header shows seq=00.
REQ-042 Stray tx_done pulses in IDLE and COLLECT_A, plus flush in IDLE -> no state change and no tx_ready pulse.
